// File: rtl/gates_vector.sv
// gates_vector: registered neighbour-gate vector unit.
// One-stage pipeline: on a valid edge, loads AND/OR/XOR neighbour relations
// of the input word; holds results otherwise. out_valid tracks in_valid by
// one cycle.
// Optional feature: define GATES_VECTOR_PARITY_EN to add the registered
// out_parity output (XOR-reduction of the sampled word).
module gates_vector #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-2:0] out_both,
    output logic [WIDTH-1:1] out_any,
    output logic [WIDTH-1:0] out_different
`ifdef GATES_VECTOR_PARITY_EN
   ,output logic             out_parity
`endif
);

    logic             valid_q;
    logic [WIDTH-2:0] both_q,  both_d;
    logic [WIDTH-1:1] any_q,   any_d;
    logic [WIDTH-1:0] diff_q,  diff_d;
`ifdef GATES_VECTOR_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Neighbour relations of the current input word (pure bitwise)
    always_comb begin
        both_d = in[WIDTH-2:0] & in[WIDTH-1:1];
        any_d  = in[WIDTH-2:0] | in[WIDTH-1:1];
        diff_d = in ^ {in[0], in[WIDTH-1:1]};
`ifdef GATES_VECTOR_PARITY_EN
        parity_d = ^in;
`endif
    end

    // Result registers: load on valid, hold otherwise; valid follows in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            both_q  <= '0;
            any_q   <= '0;
            diff_q  <= '0;
`ifdef GATES_VECTOR_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                both_q  <= both_d;
                any_q   <= any_d;
                diff_q  <= diff_d;
`ifdef GATES_VECTOR_PARITY_EN
                parity_q <= parity_d;
`endif
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_both      = both_q;
    assign out_any       = any_q;
    assign out_different = diff_q;
`ifdef GATES_VECTOR_PARITY_EN
    assign out_parity    = parity_q;
`endif

endmodule

// File: tb/tb_gates_vector.sv
// tb_gates_vector: directed + random checking of gates_vector (WIDTH=4)
// against a per-bit behavioural model, plus hand-computed literal checks.
module tb_gates_vector;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in;
    logic         out_valid;
    logic [W-2:0] out_both;
    logic [W-1:1] out_any;
    logic [W-1:0] out_different;
`ifdef GATES_VECTOR_PARITY_EN
    logic         out_parity;
`endif

    gates_vector #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in            (in),
        .out_valid     (out_valid),
        .out_both      (out_both),
        .out_any       (out_any),
        .out_different (out_different)
`ifdef GATES_VECTOR_PARITY_EN
       ,.out_parity    (out_parity)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: per-bit neighbour rules, reset/hold/valid behaviour
    logic         m_valid;
    logic [W-2:0] m_both;
    logic [W-2:0] m_any;
    logic [W-1:0] m_diff;
    logic         m_par;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_both  <= '0;
            m_any   <= '0;
            m_diff  <= '0;
            m_par   <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                logic [W-2:0] b, a;
                logic [W-1:0] d;
                logic p;
                p = 1'b0;
                for (int i = 0; i < W - 1; i++) b[i] = in[i] & in[i+1];
                for (int i = 1; i < W; i++)     a[i-1] = in[i] | in[i-1];
                for (int i = 0; i < W; i++)     d[i] = in[i] ^ in[(i+1) % W];
                for (int i = 0; i < W; i++)     p = p ^ in[i];
                m_both <= b;
                m_any  <= a;
                m_diff <= d;
                m_par  <= p;
            end
        end
    end

    // Compare process: every negedge once checking is enabled
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 64'(out_valid), 64'(m_valid));
            check("both",  64'(out_both),  64'(m_both));
            check("any",   64'(out_any),   64'(m_any));
            check("diff",  64'(out_different), 64'(m_diff));
`ifdef GATES_VECTOR_PARITY_EN
            check("parity", 64'(out_parity), 64'(m_par));
`endif
        end
    end

    task automatic apply(input logic [W-1:0] v, input logic vld);
        @(negedge clk);
        in       = v;
        in_valid = vld;
    endtask

    // Literal expectation of the word loaded on the previous edge
    task automatic lit(input string name, input logic v, input logic [2:0] b,
                       input logic [2:0] a, input logic [3:0] d);
        check({name, "_valid"}, 64'(out_valid), 64'(v));
        check({name, "_both"},  64'(out_both),  64'(b));
        check({name, "_any"},   64'(out_any),   64'(a));
        check({name, "_diff"},  64'(out_different), 64'(d));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in       = '0;
        #1;
        lit("reset", 1'b0, 3'b000, 3'b000, 4'b0000);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Directed sequence 3,6,12,9
        apply(4'd3, 1'b1);
        apply(4'd6, 1'b1);
        lit("w3", 1'b1, 3'b001, 3'b011, 4'b1010);
        apply(4'd12, 1'b1);
        lit("w6", 1'b1, 3'b010, 3'b111, 4'b0101);
        apply(4'd9, 1'b1);
        lit("w12", 1'b1, 3'b100, 3'b110, 4'b1010);
        apply(4'hF, 1'b1);
        lit("w9", 1'b1, 3'b000, 3'b101, 4'b0101);

        // Extremes
        apply(4'h0, 1'b1);
        lit("wF", 1'b1, 3'b111, 3'b111, 4'b0000);
`ifdef GATES_VECTOR_PARITY_EN
        check("wF_parity", 64'(out_parity), 64'd0);
`endif
        apply(4'h6, 1'b1);
        lit("w0", 1'b1, 3'b000, 3'b000, 4'b0000);

        // Hold: 6 valid, then 9 not valid
        apply(4'h9, 1'b0);
        apply(4'h9, 1'b0);
        lit("hold", 1'b0, 3'b010, 3'b111, 4'b0101);

        // Asynchronous reset mid-cycle with nonzero outputs
        apply(4'hF, 1'b1);
        apply(4'hF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        lit("async_rst", 1'b0, 3'b000, 3'b000, 4'b0000);
`ifdef GATES_VECTOR_PARITY_EN
        check("async_rst_parity", 64'(out_parity), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Random stream
        for (int k = 0; k < 200; k++)
            apply(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        apply(4'h0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
